ram_wr_ctrl: RTL

Frame controller on the write side of the 64-word dual-port RAM. It fills port A with a known data pattern, then drives rd_flag so the port-B read-address stage sweeps the same 64 words. It sits directly upstream of the read-address stage and produces its only control input. It is used for RAM bring-up and loopback checking.

---
 rtl/ram_wr_ctrl_pkg.sv | 16 +
 rtl/ram_wr_ctrl_if.sv | 28 ++
 rtl/ram_frame_cnt.sv | 40 ++++
 rtl/ram_wr_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ram_wr_ctrl_pkg.sv
// Shared types and default widths for the RAM write controller and the
// port-B read-address stage that consumes its rd_flag.
package ram_wr_ctrl_pkg;

  localparam int RAM_ADDR_W  = 6;
  localparam int RAM_DATA_W  = 8;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_READ  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_wr_ctrl_if.sv
// RAM port-A write bus plus the read-window flag toward the port-B stage.
interface ram_wr_ctrl_if
  import ram_wr_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) ();

  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              rd_flag;

  modport master (
    output ram_wr_en,
    output ram_wr_addr,
    output ram_wr_data,
    output rd_flag
  );

  modport slave (
    input ram_wr_en,
    input ram_wr_addr,
    input ram_wr_data,
    input rd_flag
  );

endinterface

// File: rtl/ram_frame_cnt.sv
// Address/cycle counter shared by the WRITE and READ phases. Exposes its
// next value so the owner can register outputs derived from it, and a
// terminal-count flag when the current value is all ones.
module ram_frame_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count_nxt,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear wins over enable; the count wraps naturally at 2**W.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  assign count_nxt = count_d;
  assign tc        = &count_q;

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ram_wr_ctrl.sv
// Frame controller for RAM bring-up: writes a seed-offset ramp into port A,
// waits one cycle, then opens a read window for the port-B address stage.
// Every output is a flop; next values are decoded from the next state.
module ram_wr_ctrl
  import ram_wr_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int CNT_W  = FRAME_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont_mode,
  ram_wr_ctrl_if.master    ram_if,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  state_e             state_q, state_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_flag_q, rd_flag_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [DATA_W-1:0]  seed_q, seed_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic [ADDR_W-1:0]  cnt_nxt;
  logic               cnt_tc;

  ram_frame_cnt #(
    .W (ADDR_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .count_nxt (cnt_nxt),
    .tc        (cnt_tc)
  );

  // Next-state, counter control and frame bookkeeping. The counter is held
  // at zero outside the active phases so each phase starts from address 0.
  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    seed_d       = seed_q;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (start && !stop) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d = ST_GAP;
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_GAP: begin
        cnt_clr = 1'b1;
        state_d = stop ? ST_IDLE : ST_READ;
      end
      ST_READ: begin
        if (stop) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          cnt_clr      = 1'b1;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + CNT_W'(1);
          seed_d       = seed_q + DATA_W'(1);
          state_d      = cont_mode ? ST_WRITE : ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop; the
  // write bus is forced to zero whenever no write is in progress.
  always_comb begin
    wr_en_d   = (state_d == ST_WRITE);
    rd_flag_d = (state_d == ST_READ);
    busy_d    = (state_d != ST_IDLE);
    wr_addr_d = '0;
    wr_data_d = '0;
    if (wr_en_d) begin
      wr_addr_d = cnt_nxt;
      wr_data_d = seed_d + DATA_W'(cnt_nxt);
    end
  end

  // State, output and bookkeeping registers; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_en_q      <= 1'b0;
      rd_flag_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      seed_q       <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      rd_flag_q    <= rd_flag_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      seed_q       <= seed_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign ram_if.ram_wr_en   = wr_en_q;
  assign ram_if.ram_wr_addr = wr_addr_q;
  assign ram_if.ram_wr_data = wr_data_q;
  assign ram_if.rd_flag     = rd_flag_q;
  assign busy               = busy_q;
  assign frame_done         = frame_done_q;
  assign frame_cnt          = frame_cnt_q;

endmodule
